// File: rtl/bictr_sweep_ctrl.sv
// Sweep command sequencer for the up/down counter with count-to flag.
// Loads the counter, paces it with tick, repeats or bounces passes.
module bictr_sweep_ctrl #(
   parameter int WIDTH = 4,
   parameter int REP_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [WIDTH-1:0] cmd_end,
   input  logic [REP_W-1:0] cmd_reps,
   input  logic             cmd_bounce,
   input  logic             tick,
   input  logic             abort,
   output logic [WIDTH-1:0] ctr_data,
   output logic             ctr_load_n,
   output logic             ctr_cen,
   output logic             ctr_up_dn,
   output logic [WIDTH-1:0] ctr_count_to,
   input  logic             ctr_tercnt,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] pass_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] end_q;
   logic [REP_W-1:0] reps_q;
   logic             bounce_q;
   logic             dir_q;
   logic             fwd_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] count_to_q;
   logic             up_dn_q;
   logic             load_n_q;
   logic             done_q;
   logic [REP_W-1:0] pass_cnt_q;

   logic             accept;
   logic             pass_done;
   logic             last_pass;
   logic [REP_W-1:0] pass_cnt_d;
   logic [REP_W-1:0] reps_d;
   logic             dir_d;

   // Handshake and pass bookkeeping decoded from current state
   assign cmd_ready  = reset & (state_q == S_IDLE);
   assign accept     = cmd_valid & cmd_ready;
   assign pass_done  = (state_q == S_RUN) & ctr_tercnt;
   assign pass_cnt_d = pass_cnt_q + 1'b1;
   assign last_pass  = (pass_cnt_d == reps_q);
   assign reps_d     = (cmd_reps == '0) ?
                       {{(REP_W-1){1'b0}}, 1'b1} : cmd_reps;
   assign dir_d      = (cmd_end >= cmd_start);

   // Count enable is gated by tercnt so the counter stops on count_to
   assign ctr_cen = (state_q == S_RUN) & tick & ~ctr_tercnt;

   assign ctr_data     = data_q;
   assign ctr_load_n   = load_n_q;
   assign ctr_up_dn    = up_dn_q;
   assign ctr_count_to = count_to_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign pass_cnt     = pass_cnt_q;

   // Sweep FSM with registered counter controls
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         start_q    <= '0;
         end_q      <= '0;
         reps_q     <= '0;
         bounce_q   <= 1'b0;
         dir_q      <= 1'b1;
         fwd_q      <= 1'b1;
         data_q     <= '0;
         count_to_q <= '0;
         up_dn_q    <= 1'b1;
         load_n_q   <= 1'b1;
         done_q     <= 1'b0;
         pass_cnt_q <= '0;
      end else begin
         load_n_q <= 1'b1;
         done_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  start_q    <= cmd_start;
                  end_q      <= cmd_end;
                  reps_q     <= reps_d;
                  bounce_q   <= cmd_bounce;
                  dir_q      <= dir_d;
                  fwd_q      <= 1'b1;
                  data_q     <= cmd_start;
                  count_to_q <= cmd_end;
                  up_dn_q    <= dir_d;
                  pass_cnt_q <= '0;
                  load_n_q   <= 1'b0;
                  state_q    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (pass_done) begin
                  pass_cnt_q <= pass_cnt_d;
                  if (last_pass) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else if (bounce_q) begin
                     fwd_q      <= ~fwd_q;
                     count_to_q <= fwd_q ? start_q : end_q;
                     up_dn_q    <= ~up_dn_q;
                  end else begin
                     fwd_q      <= 1'b1;
                     data_q     <= start_q;
                     count_to_q <= end_q;
                     up_dn_q    <= dir_q;
                     load_n_q   <= 1'b0;
                     state_q    <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bictr_sweep_ctrl.sv
// Directed bench for bictr_sweep_ctrl with a behavioural
// model of the downstream up/down counter.
module tb_bictr_sweep_ctrl;

   localparam int W = 4;
   localparam int R = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [W-1:0] cmd_start = '0;
   logic [W-1:0] cmd_end = '0;
   logic [R-1:0] cmd_reps = '0;
   logic         cmd_bounce = 1'b0;
   logic         tick = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] ctr_data;
   logic         ctr_load_n;
   logic         ctr_cen;
   logic         ctr_up_dn;
   logic [W-1:0] ctr_count_to;
   logic         ctr_tercnt;
   logic         busy;
   logic         done;
   logic [R-1:0] pass_cnt;

   logic [W-1:0] cnt = '0;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int cyc = 0;
   int ncen = 0;
   int nload = 0;
   int ndone = 0;
   int nbad = 0;
   bit tick_div = 1'b0;

   bictr_sweep_ctrl #(.WIDTH(W), .REP_W(R)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_start    (cmd_start),
      .cmd_end      (cmd_end),
      .cmd_reps     (cmd_reps),
      .cmd_bounce   (cmd_bounce),
      .tick         (tick),
      .abort        (abort),
      .ctr_data     (ctr_data),
      .ctr_load_n   (ctr_load_n),
      .ctr_cen      (ctr_cen),
      .ctr_up_dn    (ctr_up_dn),
      .ctr_count_to (ctr_count_to),
      .ctr_tercnt   (ctr_tercnt),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt)
   );

   always #5 clk = ~clk;

   // Downstream counter model
   always @(posedge clk) begin
      if (!ctr_load_n) cnt <= ctr_data;
      else if (ctr_cen) cnt <= ctr_up_dn ? cnt + 1'b1 : cnt - 1'b1;
   end
   assign ctr_tercnt = (cnt == ctr_count_to);

   // Event counters sampled on the active edge
   always @(posedge clk) begin
      if (ctr_cen) ncen++;
      if (!ctr_load_n) nload++;
      if (done) ndone++;
      if (ctr_cen && (!tick || ctr_tercnt)) nbad++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      tick = tick_div ? (cyc % 3 == 0) : 1'b1;
   endtask

   task automatic issue(input logic [W-1:0] s, input logic [W-1:0] e,
                        input logic [R-1:0] r, input logic b);
      cmd_start  = s;
      cmd_end    = e;
      cmd_reps   = r;
      cmd_bounce = b;
      cmd_valid  = 1'b1;
      ncen  = 0;
      nload = 0;
      ndone = 0;
      cyc   = 0;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int k = 0;
      while (!done && k < bound) begin
         step();
         k++;
      end
      chk(tag, 32'(done), 1);
   endtask

   initial begin
      // Reset values
      reset = 1'b0;
      step();
      step();
      chk("rst_ready", 32'(cmd_ready), 0);
      chk("rst_load_n", 32'(ctr_load_n), 1);
      chk("rst_cen", 32'(ctr_cen), 0);
      chk("rst_up_dn", 32'(ctr_up_dn), 1);
      chk("rst_data", 32'(ctr_data), 0);
      chk("rst_count_to", 32'(ctr_count_to), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b1;
      step();
      chk("idle_ready", 32'(cmd_ready), 1);

      // 1: 3 -> 7 single pass
      issue(4'd3, 4'd7, 8'd1, 1'b0);
      chk("t1_load_n", 32'(ctr_load_n), 0);
      chk("t1_data", 32'(ctr_data), 3);
      chk("t1_count_to", 32'(ctr_count_to), 7);
      chk("t1_up", 32'(ctr_up_dn), 1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready", 32'(cmd_ready), 0);
      step();
      chk("t1_run_load_n", 32'(ctr_load_n), 1);
      chk("t1_cnt_first", 32'(cnt), 3);
      wait_done("t1_done", 20);
      chk("t1_done_cyc", 32'(cyc), 7);
      chk("t1_pass", 32'(pass_cnt), 1);
      chk("t1_ncen", 32'(ncen), 4);
      chk("t1_nload", 32'(nload), 1);
      chk("t1_cnt_end", 32'(cnt), 7);
      step();
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_idle", 32'(busy), 0);
      chk("t1_pass_hold", 32'(pass_cnt), 1);

      // 2: 12 -> 9 twice, reload each pass
      issue(4'd12, 4'd9, 8'd2, 1'b0);
      chk("t2_up", 32'(ctr_up_dn), 0);
      wait_done("t2_done", 30);
      chk("t2_done_cyc", 32'(cyc), 11);
      chk("t2_pass", 32'(pass_cnt), 2);
      chk("t2_nload", 32'(nload), 2);
      chk("t2_ncen", 32'(ncen), 6);
      step();

      // 3: bounce 2 <-> 5, three passes
      issue(4'd2, 4'd5, 8'd3, 1'b1);
      step();
      chk("t3_up_p1", 32'(ctr_up_dn), 1);
      chk("t3_to_p1", 32'(ctr_count_to), 5);
      repeat (4) step();
      chk("t3_up_p2", 32'(ctr_up_dn), 0);
      chk("t3_to_p2", 32'(ctr_count_to), 2);
      chk("t3_cnt_p2", 32'(cnt), 5);
      chk("t3_pass_p2", 32'(pass_cnt), 1);
      repeat (4) step();
      chk("t3_up_p3", 32'(ctr_up_dn), 1);
      chk("t3_to_p3", 32'(ctr_count_to), 5);
      chk("t3_cnt_p3", 32'(cnt), 2);
      chk("t3_pass_p3", 32'(pass_cnt), 2);
      wait_done("t3_done", 20);
      chk("t3_done_cyc", 32'(cyc), 14);
      chk("t3_pass", 32'(pass_cnt), 3);
      chk("t3_nload", 32'(nload), 1);
      chk("t3_ncen", 32'(ncen), 9);
      step();

      // 4: start == end, reps 1 and reps 0
      issue(4'd6, 4'd6, 8'd1, 1'b0);
      wait_done("t4a_done", 10);
      chk("t4a_done_cyc", 32'(cyc), 3);
      chk("t4a_ncen", 32'(ncen), 0);
      chk("t4a_pass", 32'(pass_cnt), 1);
      step();
      issue(4'd6, 4'd6, 8'd0, 1'b0);
      wait_done("t4b_done", 10);
      chk("t4b_done_cyc", 32'(cyc), 3);
      chk("t4b_ncen", 32'(ncen), 0);
      chk("t4b_pass", 32'(pass_cnt), 1);
      step();

      // 5: tick every third cycle
      tick_div = 1'b1;
      issue(4'd0, 4'd3, 8'd1, 1'b0);
      wait_done("t5_done", 40);
      chk("t5_done_cyc", 32'(cyc), 11);
      chk("t5_ncen", 32'(ncen), 3);
      chk("t5_cnt", 32'(cnt), 3);
      chk("t5_bad_cen", 32'(nbad), 0);
      tick_div = 1'b0;
      step();

      // 6a: abort mid-run at count 4
      issue(4'd1, 4'd9, 8'd1, 1'b0);
      repeat (4) step();
      chk("t6a_cnt", 32'(cnt), 4);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6a_busy", 32'(busy), 0);
      chk("t6a_ready", 32'(cmd_ready), 1);
      chk("t6a_load_n", 32'(ctr_load_n), 1);
      chk("t6a_cen", 32'(ctr_cen), 0);
      chk("t6a_pass", 32'(pass_cnt), 0);
      repeat (3) step();
      chk("t6a_ndone", 32'(ndone), 0);

      // 6b: command ignored while busy, then reset mid-run
      issue(4'd1, 4'd9, 8'd1, 1'b0);
      step();
      cmd_valid = 1'b1;
      cmd_start = 4'd15;
      cmd_end   = 4'd0;
      step();
      step();
      cmd_valid = 1'b0;
      chk("t6b_data", 32'(ctr_data), 1);
      chk("t6b_count_to", 32'(ctr_count_to), 9);
      chk("t6b_up", 32'(ctr_up_dn), 1);
      chk("t6b_nload", 32'(nload), 1);
      step();
      chk("t6b_cnt", 32'(cnt), 4);
      reset = 1'b0;
      #1;
      chk("t6b_ready_low", 32'(cmd_ready), 0);
      step();
      chk("t6b_load_n", 32'(ctr_load_n), 1);
      chk("t6b_cen", 32'(ctr_cen), 0);
      chk("t6b_rst_up", 32'(ctr_up_dn), 1);
      chk("t6b_rst_data", 32'(ctr_data), 0);
      chk("t6b_rst_to", 32'(ctr_count_to), 0);
      chk("t6b_rst_done", 32'(done), 0);
      chk("t6b_rst_pass", 32'(pass_cnt), 0);
      chk("t6b_rst_busy", 32'(busy), 0);
      chk("t6b_rst_ready", 32'(cmd_ready), 0);
      reset = 1'b1;
      step();
      chk("t6b_ready", 32'(cmd_ready), 1);

      // 6c: abort wins over pass completion
      issue(4'd6, 4'd6, 8'd1, 1'b0);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6c_busy", 32'(busy), 0);
      chk("t6c_done", 32'(done), 0);
      chk("t6c_pass", 32'(pass_cnt), 0);
      step();
      chk("t6c_ndone", 32'(ndone), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
